// File: rtl/bus_scheduler.sv
// bus_scheduler
//   Round-robin scheduler for a serial system bus shared by two masters and
//   three slaves. Grants the bus to one master, decodes the two slave-select
//   bits at the head of that master's serial address, holds the grant until
//   the transaction completes, and forces a release with an error pulse on a
//   bad select code or a stall.
//
// Ports
//   clk            bus clock, rising edge
//   rst            synchronous active-high reset
//   breq1/breq2    level bus requests from master 1 / master 2
//   mvalid/mwdata  serial valid/data from the master chosen by msel (MSB first)
//   sready1..3     slave ready, 1 = slave idle
//   bgrant1/2      registered bus grants (one-hot or zero)
//   msel           master mux select (0 = master 1, 1 = master 2)
//   ssel           slave select (0 = none, 1..3 = slave 1..3)
//   berr           one-cycle error pulse (decode error or timeout)
//   busy           scheduler not idle
//   dbg_state      current FSM state for observation
//
// Handshake: mwdata is consumed only on cycles where mvalid is 1; there is no
// back-pressure toward the master. sready is a level status (1 = idle) and is
// only used to qualify completion together with the owner dropping breq.
//
// The bus outputs (bgrant*, ssel, berr, busy) are registered images of the
// FSM state, so they trail the state by one cycle. msel is written together
// with the state on the arbitration edge so the interconnect mux is already
// steered toward the winner when its grant becomes visible.

module bus_scheduler #(
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       breq1,
  input  logic       breq2,
  input  logic       mvalid,
  input  logic       mwdata,
  input  logic       sready1,
  input  logic       sready2,
  input  logic       sready3,
  output logic       bgrant1,
  output logic       bgrant2,
  output logic       msel,
  output logic [1:0] ssel,
  output logic       berr,
  output logic       busy,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_ADDR  = 3'd2,
    S_BUSY  = 3'd3,
    S_REL   = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT);

  state_t               state, state_nx;
  logic                 msel_nx;
  logic                 last, last_nx;     // last served master: 0 = m1, 1 = m2
  logic                 bit1, bit1_nx;     // first select bit
  logic [1:0]           sel, sel_nx;       // decoded slave index 0..2
  logic [CNT_WIDTH-1:0] cnt, cnt_nx;
  logic                 err, err_nx;       // current release carries an error

  logic req_own;
  logic slave_rdy;
  logic tmo;
  logic on_bus;

  assign req_own   = msel ? breq2 : breq1;
  assign tmo       = (cnt == TMO);
  assign on_bus    = (state == S_GRANT) || (state == S_ADDR) || (state == S_BUSY);
  assign dbg_state = state;

  always_comb begin
    slave_rdy = 1'b1;
    case (sel)
      2'd0:    slave_rdy = sready1;
      2'd1:    slave_rdy = sready2;
      2'd2:    slave_rdy = sready3;
      default: slave_rdy = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    msel_nx  = msel;
    last_nx  = last;
    bit1_nx  = bit1;
    sel_nx   = sel;
    cnt_nx   = cnt;
    err_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (breq1 || breq2) begin
          // On a tie the master that was not served last wins.
          msel_nx  = (breq1 && breq2) ? ~last : breq2;
          cnt_nx   = '0;
          state_nx = S_GRANT;
        end
      end
      S_GRANT: begin
        cnt_nx = cnt + 1'b1;
        if (tmo) begin
          err_nx   = 1'b1;
          state_nx = S_REL;
        end else if (!req_own) begin
          state_nx = S_REL;
        end else if (mvalid) begin
          bit1_nx  = mwdata;
          state_nx = S_ADDR;
        end
      end
      S_ADDR: begin
        cnt_nx = cnt + 1'b1;
        if (tmo) begin
          err_nx   = 1'b1;
          state_nx = S_REL;
        end else if (!req_own) begin
          state_nx = S_REL;
        end else if (mvalid) begin
          if (bit1 && mwdata) begin
            err_nx   = 1'b1;     // select code 11 has no slave behind it
            state_nx = S_REL;
          end else begin
            sel_nx   = {bit1, mwdata};
            cnt_nx   = '0;
            state_nx = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_nx = cnt + 1'b1;
        if (tmo) begin
          err_nx   = 1'b1;
          state_nx = S_REL;
        end else if (!req_own && slave_rdy) begin
          state_nx = S_REL;
        end
      end
      S_REL: begin
        last_nx  = msel;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      msel    <= 1'b0;
      last    <= 1'b1;
      bit1    <= 1'b0;
      sel     <= 2'd0;
      cnt     <= '0;
      err     <= 1'b0;
      bgrant1 <= 1'b0;
      bgrant2 <= 1'b0;
      ssel    <= 2'd0;
      berr    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      msel    <= msel_nx;
      last    <= last_nx;
      bit1    <= bit1_nx;
      sel     <= sel_nx;
      cnt     <= cnt_nx;
      err     <= err_nx;
      bgrant1 <= on_bus && !msel;
      bgrant2 <= on_bus && msel;
      ssel    <= (state == S_BUSY) ? (sel + 2'd1) : 2'd0;
      berr    <= (state == S_REL) && err;
      busy    <= (state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_bus_scheduler.sv
// Testbench for bus_scheduler: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// transaction-level model of bus ownership.

module tb_bus_scheduler;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       breq1, breq2, mvalid, mwdata, sready1, sready2, sready3;
  logic       bgrant1, bgrant2, msel, berr, busy;
  logic [1:0] ssel;
  logic [2:0] dbg_state;

  bus_scheduler #(.TIMEOUT(TMO), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .breq1(breq1), .breq2(breq2), .mvalid(mvalid),
    .mwdata(mwdata), .sready1(sready1), .sready2(sready2), .sready3(sready3),
    .bgrant1(bgrant1), .bgrant2(bgrant2), .msel(msel), .ssel(ssel),
    .berr(berr), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Ownership view: owner (-1 = nobody), number of select bits seen, the
  // select value, cycles spent since the grant / since the slave was chosen,
  // and whether the owner is in its one release cycle. DUT outputs show the
  // view as it stood one edge earlier; msel shows the current owner choice.
  int m_owner, m_bits, m_sel, m_age, m_last, m_msel;
  bit m_rel, m_rel_err;
  logic       e_g1, e_g2, e_msel, e_berr, e_busy;
  logic [1:0] e_ssel;

  function automatic bit slave_idle(input int s);
    if (s == 0) return sready1;
    if (s == 1) return sready2;
    return sready3;
  endfunction

  always @(posedge clk) begin
    bit req, rel_now, age_clr;
    if (rst) begin
      m_owner = -1; m_bits = 0; m_sel = 0; m_age = 0; m_last = 1; m_msel = 0;
      m_rel = 0; m_rel_err = 0;
      e_g1 = 0; e_g2 = 0; e_msel = 0; e_ssel = 0; e_berr = 0; e_busy = 0;
    end else begin
      e_busy = (m_owner >= 0);
      e_g1   = (m_owner == 0) && !m_rel;
      e_g2   = (m_owner == 1) && !m_rel;
      e_ssel = (m_owner >= 0 && !m_rel && m_bits == 2) ? 2'(m_sel + 1) : 2'd0;
      e_berr = m_rel && m_rel_err;
      if (m_owner < 0) begin
        if (breq1 || breq2) begin
          if (breq1 && breq2) m_owner = (m_last == 0) ? 1 : 0;
          else                m_owner = breq1 ? 0 : 1;
          m_msel = m_owner; m_bits = 0; m_sel = 0; m_age = 0;
        end
      end else if (m_rel) begin
        m_last = m_owner; m_owner = -1; m_rel = 0; m_rel_err = 0;
      end else begin
        req = (m_owner == 0) ? breq1 : breq2;
        rel_now = 0; age_clr = 0;
        if (m_age == TMO) begin
          rel_now = 1; m_rel_err = 1;
        end else if (m_bits < 2) begin
          if (!req) rel_now = 1;
          else if (mvalid) begin
            m_sel = m_sel * 2 + int'(mwdata);
            m_bits++;
            if (m_bits == 2) begin
              if (m_sel == 3) begin rel_now = 1; m_rel_err = 1; end
              else age_clr = 1;
            end
          end
        end else if (!req && slave_idle(m_sel)) begin
          rel_now = 1;
        end
        if (rel_now) m_rel = 1;
        else if (age_clr) m_age = 0;
        else m_age++;
      end
      e_msel = 1'(m_msel);
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("bgrant1", bgrant1, e_g1);
      chk("bgrant2", bgrant2, e_g2);
      chk("msel",    msel,    e_msel);
      chk("ssel",    ssel,    e_ssel);
      chk("berr",    berr,    e_berr);
      chk("busy",    busy,    e_busy);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    breq1 = 0; breq2 = 0; mvalid = 0; mwdata = 0;
    sready1 = 1; sready2 = 1; sready3 = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; idle_inputs();
    @(negedge clk);
    rst = 0;
  endtask

  function automatic bit sig(input int which);
    case (which)
      1: return bgrant1;
      2: return bgrant2;
      3: return berr;
      default: return ssel != 2'd0;
    endcase
  endfunction

  // Counts negedges until the selected output is high; expiry is a failure.
  task automatic wait_sig(input string name, input int which, input int budget, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (sig(which)) break;
      if (n >= budget) begin
        checks++; errors++;
        $display("FAIL %s: no event within %0d cycles", name, budget);
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, berr_cnt, ssel_max;
    bit p1, p2;
    int seq[$];

    rst = 1; idle_inputs();
    @(posedge clk); @(posedge clk);
    #1;
    chk("rst_bgrant1", bgrant1, 0); chk("rst_bgrant2", bgrant2, 0);
    chk("rst_msel", msel, 0); chk("rst_ssel", ssel, 0);
    chk("rst_berr", berr, 0); chk("rst_busy", busy, 0);
    cmp_en = 1;

    // Single grant, select 01 -> slave 2
    do_reset();
    breq1 = 1;
    @(negedge clk); chk("t1_grant_lat", bgrant1, 0); chk("t1_msel", msel, 0);
    mvalid = 1; mwdata = 0;
    @(negedge clk); chk("t1_grant", bgrant1, 1); chk("t1_busy", busy, 1);
    mwdata = 1;
    @(negedge clk); chk("t1_ssel_early", ssel, 0);
    mvalid = 0; sready2 = 0;
    @(negedge clk); chk("t1_ssel", ssel, 2);
    breq1 = 0;
    @(negedge clk); chk("t1_hold", bgrant1, 1);
    sready2 = 1;
    @(negedge clk); chk("t1_rel_pending", bgrant1, 1);
    @(negedge clk); chk("t1_released", bgrant1, 0); chk("t1_ssel_rel", ssel, 0);
    chk("t1_busy_rel", busy, 1); chk("t1_berr", berr, 0);
    @(negedge clk); chk("t1_idle", busy, 0);

    // Round robin with both masters requesting continuously
    do_reset();
    breq1 = 1; breq2 = 1; mvalid = 1; mwdata = 1;
    p1 = 0; p2 = 0; seq = {};
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bgrant1 && !p1) seq.push_back(1);
      if (bgrant2 && !p2) seq.push_back(2);
      p1 = bgrant1; p2 = bgrant2;
    end
    chk("t2_grants", (seq.size() >= 3) ? 8'd1 : 8'd0, 1);
    chk("t2_first",  (seq.size() > 0) ? 8'(seq[0]) : 8'd0, 1);
    chk("t2_second", (seq.size() > 1) ? 8'(seq[1]) : 8'd0, 2);
    chk("t2_third",  (seq.size() > 2) ? 8'(seq[2]) : 8'd0, 1);

    // Decode error from master 2
    do_reset();
    breq2 = 1; mvalid = 1; mwdata = 1;
    berr_cnt = 0; ssel_max = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (berr) berr_cnt++;
      if (int'(ssel) > ssel_max) ssel_max = int'(ssel);
    end
    chk("t3_berr_once", 8'(berr_cnt), 1);
    chk("t3_ssel_zero", 8'(ssel_max), 0);
    breq2 = 0; mvalid = 0;

    // Timeout in GRANT: no mvalid
    do_reset();
    breq1 = 1;
    wait_sig("t4_grant", 1, 10, n);
    wait_sig("t4_berr", 3, 20, n);
    chk("t4_tmo_grant", 8'(n), TMO + 1);
    breq1 = 0;
    repeat (3) @(negedge clk);

    // Timeout in BUSY: slave 1 never idle
    breq1 = 1; mvalid = 1; mwdata = 0; sready1 = 0;
    wait_sig("t4b_ssel", 4, 10, n);
    chk("t4b_ssel_val", ssel, 1);
    mvalid = 0;
    wait_sig("t4b_berr", 3, 20, n);
    chk("t4b_tmo_busy", 8'(n), TMO + 1);
    breq1 = 0; sready1 = 1;
    repeat (3) @(negedge clk);

    // Early drop in GRANT
    do_reset();
    breq1 = 1;
    wait_sig("t5_grant", 1, 10, n);
    breq1 = 0;
    berr_cnt = 0; ssel_max = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (berr) berr_cnt++;
      if (int'(ssel) > ssel_max) ssel_max = int'(ssel);
    end
    chk("t5_no_berr", 8'(berr_cnt), 0);
    chk("t5_ssel", 8'(ssel_max), 0);
    chk("t5_released", bgrant1, 0);

    // Reset during BUSY, then pending master 2 gets the bus
    do_reset();
    breq1 = 1; breq2 = 1; mvalid = 1; mwdata = 0; sready1 = 0;
    wait_sig("t6_busy", 4, 10, n);
    chk("t6_owner", bgrant1, 1);
    rst = 1; breq1 = 0; mvalid = 0;
    @(negedge clk);
    chk("t6_g1", bgrant1, 0); chk("t6_g2", bgrant2, 0); chk("t6_ssel", ssel, 0);
    chk("t6_busy", busy, 0); chk("t6_berr", berr, 0); chk("t6_msel", msel, 0);
    rst = 0; sready1 = 1;
    wait_sig("t6_regrant", 2, 6, n);
    chk("t6_regrant_lat", 8'(n), 2);
    breq2 = 0;
    repeat (4) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (breq1) breq1 = ($urandom_range(0, 11) != 0);
      else       breq1 = ($urandom_range(0, 5) == 0);
      if (breq2) breq2 = ($urandom_range(0, 11) != 0);
      else       breq2 = ($urandom_range(0, 5) == 0);
      mvalid  = ($urandom_range(0, 2) == 0);
      mwdata  = 1'($urandom_range(0, 1));
      sready1 = ($urandom_range(0, 3) != 0);
      sready2 = ($urandom_range(0, 3) != 0);
      sready3 = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 699) == 0);
    end
    @(negedge clk);
    rst = 0; idle_inputs();
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
